// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one spi_mt master between NREQ requesters.
// Latches the winner's command, launches the master and returns ack/err/rdata.
module spi_req_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned A_WIDTH = 8,
    parameter int unsigned D_WIDTH = 16,
    parameter int unsigned TMO_CYC = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ-1:0]           req_rw,
    input  logic [NREQ*A_WIDTH-1:0]   req_addr,
    input  logic [NREQ*D_WIDTH-1:0]   req_wdata,
    output logic [NREQ-1:0]           gnt,
    output logic [NREQ-1:0]           ack,
    output logic                      err,
    output logic [D_WIDTH-1:0]        rdata,
    output logic                      busy,
    output logic                      m_start,
    output logic                      m_r_w,
    output logic [A_WIDTH-1:0]        m_w_addr,
    output logic [A_WIDTH-1:0]        m_r_addr,
    output logic [D_WIDTH-1:0]        m_w_data,
    input  logic [D_WIDTH-1:0]        m_r_data,
    input  logic                      m_cs
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(TMO_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_LO,
        S_WAIT_HI,
        S_DONE
    } state_e;

    typedef struct packed {
        logic               rw;
        logic [A_WIDTH-1:0] addr;
        logic [D_WIDTH-1:0] wdata;
    } cmd_t;

    // Unpack the flat requester buses so the winner can be selected by index.
    logic [A_WIDTH-1:0] addr_a  [NREQ];
    logic [D_WIDTH-1:0] wdata_a [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_a[g]  = req_addr[g*A_WIDTH +: A_WIDTH];
        assign wdata_a[g] = req_wdata[g*D_WIDTH +: D_WIDTH];
    end

    state_e             state_q, state_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic [IW-1:0]      win_q, win_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [NREQ-1:0]    ack_q, ack_d;
    logic               err_q, err_d;
    logic [D_WIDTH-1:0] rdata_q, rdata_d;
    logic               busy_q, busy_d;
    logic               start_q, start_d;
    cmd_t               cmd_q, cmd_d;

    logic               found;
    logic [IW-1:0]      pick;
    int unsigned        idx;
    logic               tmo;

    // First set request at or above the rr pointer, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = 32'(rr_q) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req[IW'(idx)]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    assign tmo = (cnt_q == CW'(TMO_CYC - 1));

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        start_d = 1'b0;
        cmd_d   = cmd_q;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d     = S_LAUNCH;
                    win_d       = pick;
                    gnt_d       = NREQ'(1) << pick;
                    cmd_d.rw    = req_rw[pick];
                    cmd_d.addr  = addr_a[pick];
                    cmd_d.wdata = wdata_a[pick];
                    start_d     = 1'b1;
                    cnt_d       = '0;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT_LO;
                cnt_d   = '0;
            end
            S_WAIT_LO: begin
                if (!m_cs) begin
                    state_d = S_WAIT_HI;
                    cnt_d   = '0;
                end else if (tmo) begin
                    state_d = S_DONE;
                    ack_d   = gnt_q;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_HI: begin
                // Read data is captured on the cs rising edge so it is valid with ack.
                if (m_cs) begin
                    state_d = S_DONE;
                    ack_d   = gnt_q;
                    cnt_d   = '0;
                    if (cmd_q.rw) begin
                        rdata_d = m_r_data;
                    end
                end else if (tmo) begin
                    state_d = S_DONE;
                    ack_d   = gnt_q;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
                rr_d    = (win_q == IW'(NREQ - 1)) ? '0 : win_q + IW'(1);
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            win_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            cmd_q   <= cmd_d;
        end
    end

    assign gnt      = gnt_q;
    assign ack      = ack_q;
    assign err      = err_q;
    assign rdata    = rdata_q;
    assign busy     = busy_q;
    assign m_start  = start_q;
    assign m_r_w    = cmd_q.rw;
    assign m_w_addr = cmd_q.addr;
    assign m_r_addr = cmd_q.addr;
    assign m_w_data = cmd_q.wdata;

endmodule
